// File: rtl/sm_hex_scanner.sv
// sm_hex_scanner: scans a hex word onto a multiplexed seven-segment display
// with a frame-synchronous shadow copy, leading-zero blanking and decimal points.
module sm_hex_scanner #(
  parameter int DIGITS         = 8,
  parameter int PRESCALE       = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dot_mask,
  input  logic                  i_enable,
  input  logic                  i_blank_zeros,
  output logic [DIGITS-1:0]     o_anodes,
  output logic [6:0]            o_segments,
  output logic                  o_dot,
  output logic                  o_frame_done
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [PRESCALE-1:0] r_presc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_shadow_value;
  logic [DIGITS-1:0]   r_shadow_dot;
  logic [DIGITS-1:0]   r_anodes;
  logic [6:0]          r_segments;
  logic                r_dot;
  logic                r_frame_done;
  logic                w_tick;
  logic                w_wrap;
  logic                w_blank;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg_hi;
  logic [DIGITS-1:0]   w_an;
  logic [DIGITS-1:0]   w_zero_above;
  // w_zero_above[i]: this nibble and every more-significant one are zero
  for (genvar g = 0; g < DIGITS; g++) begin : g_zero
    if (g == DIGITS - 1) begin : g_top
      assign w_zero_above[g] = r_shadow_value[4*g +: 4] == 4'd0;
    end else begin : g_mid
      assign w_zero_above[g] = (r_shadow_value[4*g +: 4] == 4'd0) && w_zero_above[g+1];
    end
  end
  always_comb begin
    w_tick   = i_enable && (r_presc == '1);
    w_wrap   = w_tick && (r_idx == IW'(DIGITS - 1));
    w_nib    = r_shadow_value[{r_idx, 2'b00} +: 4];
    w_blank  = i_blank_zeros && (r_idx != '0) && w_zero_above[r_idx];
    w_seg_hi = w_blank ? 7'h00 : HEX[w_nib*7 +: 7];
    w_an     = (DIGITS'(1) << r_idx) ^ {DIGITS{AN_ACTIVE_LOW}};
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_enable) begin
      r_presc        <= '0;
      r_idx          <= '0;
      r_shadow_value <= i_rst_n ? i_value : '0;
      r_shadow_dot   <= i_rst_n ? i_dot_mask : '0;
      r_anodes       <= {DIGITS{AN_ACTIVE_LOW}};
      r_segments     <= {7{SEG_ACTIVE_LOW}};
      r_dot          <= SEG_ACTIVE_LOW;
      r_frame_done   <= 1'b0;
    end else begin
      r_presc <= r_presc + PRESCALE'(1);
      if (w_tick) r_idx <= w_wrap ? '0 : r_idx + IW'(1);
      if (w_wrap) begin
        r_shadow_value <= i_value;
        r_shadow_dot   <= i_dot_mask;
      end
      r_anodes     <= w_an;
      r_segments   <= w_seg_hi ^ {7{SEG_ACTIVE_LOW}};
      r_dot        <= r_shadow_dot[r_idx] ^ SEG_ACTIVE_LOW;
      r_frame_done <= w_wrap;
    end
  end
  assign o_anodes     = r_anodes;
  assign o_segments   = r_segments;
  assign o_dot        = r_dot;
  assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_sm_hex_scanner.sv
// tb_sm_hex_scanner: directed scoreboard bench for an 8-digit and a 6-digit scanner
module tb_sm_hex_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_en, a_blank, b_en, b_blank;
  logic [31:0] a_value;
  logic [7:0]  a_dot_mask;
  logic [23:0] b_value;
  logic [5:0]  b_dot_mask;
  logic [7:0]  a_an;
  logic [6:0]  a_seg;
  logic        a_dot, a_fd;
  logic [5:0]  b_an;
  logic [6:0]  b_seg;
  logic        b_dot, b_fd;
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  int          checks = 0;
  int          errors = 0;
  int          gap;
  always #5 clk = ~clk;
  sm_hex_scanner #(.DIGITS(8), .PRESCALE(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(a_value), .i_dot_mask(a_dot_mask),
    .i_enable(a_en), .i_blank_zeros(a_blank),
    .o_anodes(a_an), .o_segments(a_seg), .o_dot(a_dot), .o_frame_done(a_fd)
  );
  sm_hex_scanner #(.DIGITS(6), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(b_value), .i_dot_mask(b_dot_mask),
    .i_enable(b_en), .i_blank_zeros(b_blank),
    .o_anodes(b_an), .o_segments(b_seg), .o_dot(b_dot), .o_frame_done(b_fd)
  );
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction
  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one entry per cycle: {anodes(8), segments, dot, frameDone}, active-low polarities
  task automatic push_frame(input bit sel, input logic [31:0] val, input logic [7:0] dots,
                            input bit blank, input int ndig, input int hold);
    logic [7:0]  mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [16:0] e;
    mask = 8'hFF >> (8 - ndig);
    for (int d = 0; d < ndig; d++) begin
      for (int h = 0; h < hold; h++) begin
        an  = ~(8'd1 << d) & mask;
        seg = (blank && d > 0 && (val >> (4*d)) == 32'd0) ? 7'h7F : ~hex7(val[4*d +: 4]);
        e   = {an, seg, ~dots[d], (d == ndig - 1) && (h == hold - 1)};
        if (sel) qb.push_back(e); else qa.push_back(e);
      end
    end
  endtask
  task automatic run_a(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (qa.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s observed=%h expected=none-queued", tag, {a_an, a_seg, a_dot, a_fd});
      end else check($sformatf("%s[%0d]", tag, i), {a_an, a_seg, a_dot, a_fd}, qa.pop_front());
    end
  endtask
  task automatic run_b(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (qb.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s observed=%h expected=none-queued", tag, {2'b00, b_an, b_seg, b_dot, b_fd});
      end else check($sformatf("%s[%0d]", tag, i), {2'b00, b_an, b_seg, b_dot, b_fd}, qb.pop_front());
    end
  endtask
  initial begin
    a_en = 1'b1; a_blank = 1'b0; a_value = 32'h89ABCDEF; a_dot_mask = 8'h00;
    b_en = 1'b0; b_blank = 1'b0; b_value = 24'h5A0F3C; b_dot_mask = 6'b100001;
    repeat (3) @(negedge clk);
    check("reset_a", {a_an, a_seg, a_dot, a_fd}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    check("reset_b", {2'b00, b_an, b_seg, b_dot, b_fd}, {8'h3F, 7'h7F, 1'b1, 1'b0});
    rst_n = 1'b1;
    push_frame(0, 32'h0, 8'h00, 0, 8, 4);
    run_a(32, "reset_shadow_frame");
    push_frame(0, 32'h89ABCDEF, 8'h00, 0, 8, 4);
    run_a(8, "decode");
    a_value = 32'h11111111;
    run_a(24, "decode");
    push_frame(0, 32'h11111111, 8'h00, 0, 8, 4);
    run_a(13, "tear_old");
    a_value = 32'h22222222;
    run_a(19, "tear_old");
    push_frame(0, 32'h22222222, 8'h00, 0, 8, 4);
    run_a(32, "tear_new");
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (a_fd) begin gap = i; break; end
    end
    check("frame_gap", 17'(gap), 17'd32);
    a_blank = 1'b1; a_value = 32'h00000A05; a_dot_mask = 8'hA5;
    push_frame(0, 32'h22222222, 8'h00, 1, 8, 4);
    run_a(32, "blank_nonzero");
    a_value = 32'h0;
    push_frame(0, 32'h00000A05, 8'hA5, 1, 8, 4);
    run_a(32, "blank_a05");
    push_frame(0, 32'h0, 8'hA5, 1, 8, 4);
    run_a(32, "blank_zero");
    push_frame(0, 32'h0, 8'hA5, 1, 8, 4);
    run_a(21, "pre_disable");
    a_en = 1'b0;
    qa.delete();
    repeat (2) qa.push_back({8'hFF, 7'h7F, 1'b1, 1'b0});
    run_a(1, "disabled");
    a_value = 32'h12345678; a_blank = 1'b0; a_dot_mask = 8'h00;
    run_a(1, "disabled");
    a_en = 1'b1;
    push_frame(0, 32'h12345678, 8'h00, 0, 8, 4);
    run_a(32, "reenable");
    b_en = 1'b1;
    repeat (3) push_frame(1, {8'h00, b_value}, {2'b00, b_dot_mask}, 0, 6, 2);
    run_b(36, "nonpow2");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
